// File: rtl/uart_link.sv
// Full-duplex UART: parametrised data width, parity and stop bits, valid/ready on both sides.
// RX holds each word until taken and flags overrun, parity and framing errors.
module uart_link #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] FULL_LD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != 0);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_WAIT_H = 3'd5;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [2:0]           tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_tick_c;

    logic                 rx_meta_q, rxs_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_out_q, rx_perr_out_d;
    logic                 rx_ferr_out_q, rx_ferr_out_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_tick_c, rx_done_c;

    assign tx_tick_c = (tx_cnt_q == '0);
    assign rx_tick_c = (rx_cnt_q == '0);

    // Transmitter: one bit per CLKS_PER_BIT, data shifted out LSB first
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_of(tx_data);
                    tx_line_d  = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_cnt_d   = FULL_LD;
                    tx_state_d = TX_START;
                end
            end
            TX_START, TX_DATA: begin
                if (!tx_tick_c) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_cnt_d = FULL_LD;
                    if (tx_state_q == TX_DATA && tx_bit_q == LAST_DATA) begin
                        tx_bit_d   = '0;
                        tx_line_d  = HAS_PAR ? tx_par_q : 1'b1;
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        if (tx_state_q == TX_DATA) begin
                            tx_bit_d = tx_bit_q + BW'(1);
                        end else begin
                            tx_bit_d = '0;
                        end
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_state_d = TX_DATA;
                    end
                end
            end
            TX_PARITY: begin
                if (!tx_tick_c) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_cnt_d   = FULL_LD;
                    tx_bit_d   = '0;
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (!tx_tick_c) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else if (tx_bit_q == LAST_STOP) begin
                    tx_bit_d   = '0;
                    tx_ready_d = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                    tx_cnt_d = FULL_LD;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    // Receiver: half-bit start check, then mid-bit samples every CLKS_PER_BIT
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_d     = rx_perr_q;
        rx_ferr_d     = rx_ferr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_perr_out_d = rx_perr_out_q;
        rx_ferr_out_d = rx_ferr_out_q;
        rx_ovr_d      = 1'b0;
        rx_done_c     = 1'b0;
        if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_H && !rx_tick_c) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    rx_cnt_d   = HALF_LD;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick_c) begin
                    rx_cnt_d   = FULL_LD;
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                    rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick_c) begin
                    rx_cnt_d   = FULL_LD;
                    rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_DATA) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick_c) begin
                    rx_cnt_d   = FULL_LD;
                    rx_perr_d  = (rxs_q != parity_of(rx_shift_q));
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick_c) begin
                    rx_cnt_d  = FULL_LD;
                    rx_ferr_d = rx_ferr_q | ~rxs_q;
                    if (rx_bit_q == LAST_STOP) begin
                        rx_bit_d   = '0;
                        rx_done_c  = 1'b1;
                        rx_state_d = rx_ferr_d ? RX_WAIT_H : RX_IDLE;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
            end
            RX_WAIT_H: begin
                if (rxs_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // A completion coinciding with a take replaces the held word without overrun
        if (rx_done_c) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d     = rx_shift_q;
                rx_perr_out_d = rx_perr_d;
                rx_ferr_out_d = rx_ferr_d;
                rx_valid_d    = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_line_q     <= 1'b1;
            tx_ready_q    <= 1'b1;
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_out_q <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_line_q     <= tx_line_d;
            tx_ready_q    <= tx_ready_d;
            rx_meta_q     <= uart_rx;
            rxs_q         <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_out_q <= rx_ferr_out_d;
            rx_ovr_q      <= rx_ovr_d;
        end
    end

    assign uart_tx       = tx_line_q;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_out_q;
    assign rx_frame_err  = rx_ferr_out_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: an 8N1 instance (A, loopback capable) and a 7E2 instance (B), both at 16 clks/bit.
module tb_uart_link;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       line_a, loop_a, uart_rx_a, uart_tx_a, tx_valid_a, tx_ready_a;
    logic       rx_valid_a, rx_ready_a, rx_perr_a, rx_ferr_a, rx_ovr_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       line_b, uart_tx_b, tx_valid_b, tx_ready_b;
    logic       rx_valid_b, rx_ready_b, rx_perr_b, rx_ferr_b, rx_ovr_b;
    logic [6:0] tx_data_b, rx_data_b;

    assign uart_rx_a = loop_a ? uart_tx_a : line_a;

    uart_link #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .uart_rx(uart_rx_a), .uart_tx(uart_tx_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a));

    uart_link #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .uart_rx(line_b), .uart_tx(uart_tx_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sel;
        logic [15:0] bits;
        int          nbits;
        logic [8:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } rx_vec_t;
    rx_vec_t vecs [8];

    logic [7:0] cap_data [$];
    logic       cap_perr [$];
    logic       cap_ferr [$];
    bit         cap_en = 1'b0;
    bit         cnt_ready_en = 1'b0;
    int         ovr_cnt_a = 0;
    int         ready_low_cnt = 0;
    int         lat;

    // Word capture and pulse counting, sampled just after the falling edge
    always @(negedge clk) begin
        #2;
        if (cap_en && rx_valid_a && rx_ready_a) begin
            cap_data.push_back(rx_data_a);
            cap_perr.push_back(rx_perr_a);
            cap_ferr.push_back(rx_ferr_a);
        end
        if (rx_ovr_a) ovr_cnt_a++;
        if (cnt_ready_en && !tx_ready_a) ready_low_cnt++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish, required finish within 60000 cycles");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic drive_frame(input bit sel, input logic [15:0] bits, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (sel) line_b = bits[k]; else line_a = bits[k];
            repeat (16) @(negedge clk);
        end
        if (sel) line_b = 1'b1; else line_a = 1'b1;
    endtask

    task automatic wait_valid(input bit sel, input string name);
        int i = 0;
        while (!(sel ? rx_valid_b : rx_valid_a) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(sel ? rx_valid_b : rx_valid_a), 32'd1);
    endtask

    task automatic take(input bit sel);
        if (sel) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
        @(negedge clk);
        if (sel) rx_ready_b = 1'b0; else rx_ready_a = 1'b0;
        check("rx_valid_cleared", 32'(sel ? rx_valid_b : rx_valid_a), 32'd0);
    endtask

    // Handshake one word at a negedge, then check every line bit at mid-bit and tx_ready around it
    task automatic tx_frame(input bit sel, input logic [8:0] data, input logic [15:0] exp_bits,
                            input int nbits, input logic [8:0] next_data, input bit next_valid);
        if (sel) begin tx_data_b = 7'(data); tx_valid_b = 1'b1; end
        else begin tx_data_a = 8'(data); tx_valid_a = 1'b1; end
        check("tx_ready_before", 32'(sel ? tx_ready_b : tx_ready_a), 32'd1);
        @(negedge clk);
        check("tx_start_latency", 32'(sel ? uart_tx_b : uart_tx_a), 32'd0);
        if (sel) begin tx_data_b = 7'(next_data); tx_valid_b = next_valid; end
        else begin tx_data_a = 8'(next_data); tx_valid_a = next_valid; end
        for (int k = 0; k < nbits; k++) begin
            repeat (8) @(negedge clk);
            check($sformatf("tx_bit%0d", k), 32'(sel ? uart_tx_b : uart_tx_a), 32'(exp_bits[k]));
            check("tx_ready_busy", 32'(sel ? tx_ready_b : tx_ready_a), 32'd0);
            repeat (8) @(negedge clk);
        end
        check("tx_ready_after", 32'(sel ? tx_ready_b : tx_ready_a), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        line_a = 1'b1; line_b = 1'b1; loop_a = 1'b0;
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;

        vecs[0] = '{1'b1, 16'({2'b11, 1'b0, 7'h55, 1'b0}), 11, 9'h055, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'({2'b11, 1'b1, 7'h55, 1'b0}), 11, 9'h055, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'({2'b01, 1'b0, 7'h55, 1'b0}), 11, 9'h055, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'({2'b11, 1'b1, 7'h2A, 1'b0}), 11, 9'h02A, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'({2'b00, 1'b0, 7'h2A, 1'b0}), 11, 9'h02A, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'({1'b1, 8'h81, 1'b0}),        10, 9'h081, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'({1'b0, 8'hFF, 1'b0}),        10, 9'h0FF, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'({1'b1, 8'h00, 1'b0}),        10, 9'h000, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_uart_tx_a", 32'(uart_tx_a), 32'd1);
        check("rst_tx_ready_a", 32'(tx_ready_a), 32'd1);
        check("rst_rx_valid_a", 32'(rx_valid_a), 32'd0);
        check("rst_rx_data_a", 32'(rx_data_a), 32'd0);
        check("rst_flags_a", 32'({rx_perr_a, rx_ferr_a, rx_ovr_a}), 32'd0);
        check("rst_uart_tx_b", 32'(uart_tx_b), 32'd1);
        check("rst_tx_ready_b", 32'(tx_ready_b), 32'd1);
        check("rst_rx_b", 32'({rx_valid_b, rx_perr_b, rx_ferr_b, rx_ovr_b}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 loopback, 0xA5 then 0x3C queued while the first is in flight
        loop_a = 1'b1; rx_ready_a = 1'b1; cap_en = 1'b1; cnt_ready_en = 1'b1;
        @(negedge clk);
        tx_frame(1'b0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 10, 9'h03C, 1'b1);
        tx_frame(1'b0, 9'h03C, 16'({1'b1, 8'h3C, 1'b0}), 10, 9'h000, 1'b0);
        cnt_ready_en = 1'b0;
        repeat (20) @(negedge clk);
        check("loop_words", 32'(cap_data.size()), 32'd2);
        if (cap_data.size() == 2) begin
            check("loop_word0", 32'(cap_data[0]), 32'hA5);
            check("loop_word1", 32'(cap_data[1]), 32'h3C);
            check("loop_flags", 32'({cap_perr[0], cap_ferr[0], cap_perr[1], cap_ferr[1]}), 32'd0);
        end
        check("tx_ready_low_cycles", 32'(ready_low_cnt), 32'd320);
        cap_en = 1'b0; rx_ready_a = 1'b0; loop_a = 1'b0;
        repeat (10) @(negedge clk);

        // 7E2 transmit of 0x55: even parity bit 0, two stop bits
        tx_frame(1'b1, 9'h055, 16'({2'b11, 1'b0, 7'h55, 1'b0}), 11, 9'h000, 1'b0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            drive_frame(vecs[i].sel, vecs[i].bits, vecs[i].nbits);
            repeat (4) @(negedge clk);
            wait_valid(vecs[i].sel, $sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_data", i),
                  32'(vecs[i].sel ? 9'(rx_data_b) : 9'(rx_data_a)), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_perr", i),
                  32'(vecs[i].sel ? rx_perr_b : rx_perr_a), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i),
                  32'(vecs[i].sel ? rx_ferr_b : rx_ferr_a), 32'(vecs[i].exp_ferr));
            take(vecs[i].sel);
            repeat (20) @(negedge clk);
        end

        // 4-cycle start glitch, then 0x81 with line-edge to rx_valid latency
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start_no_word", 32'(rx_valid_a), 32'd0);
        fork
            drive_frame(1'b0, 16'({1'b1, 8'h81, 1'b0}), 10);
            begin
                lat = 0;
                while (!rx_valid_a && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("rx_latency", 32'(lat), 32'd155);
        check("after_glitch_data", 32'(rx_data_a), 32'h81);
        check("after_glitch_ferr", 32'(rx_ferr_a), 32'd0);
        take(1'b0);
        repeat (10) @(negedge clk);

        // Overrun: 0x22 arrives while 0x11 is still held
        lat = ovr_cnt_a;
        drive_frame(1'b0, 16'({1'b1, 8'h11, 1'b0}), 10);
        repeat (5) @(negedge clk);
        drive_frame(1'b0, 16'({1'b1, 8'h22, 1'b0}), 10);
        repeat (20) @(negedge clk);
        check("ovr_valid_held", 32'(rx_valid_a), 32'd1);
        check("ovr_data_kept", 32'(rx_data_a), 32'h11);
        check("ovr_pulses", 32'(ovr_cnt_a - lat), 32'd1);
        take(1'b0);
        repeat (10) @(negedge clk);

        // Take in the very cycle a new word completes: replaced, no overrun
        drive_frame(1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10);
        wait_valid(1'b0, "held_5a_valid");
        repeat (10) @(negedge clk);
        lat = ovr_cnt_a;
        fork
            drive_frame(1'b0, 16'({1'b1, 8'hC3, 1'b0}), 10);
            begin
                repeat (154) @(negedge clk);
                rx_ready_a = 1'b1;
                @(negedge clk);
                rx_ready_a = 1'b0;
                check("same_cycle_valid", 32'(rx_valid_a), 32'd1);
                check("same_cycle_data", 32'(rx_data_a), 32'hC3);
            end
        join
        repeat (5) @(negedge clk);
        check("same_cycle_no_ovr", 32'(ovr_cnt_a - lat), 32'd0);
        take(1'b0);
        repeat (10) @(negedge clk);

        // Break for 40 bit times yields one 0x00 with frame error, then 0x7E cleanly
        cap_data.delete(); cap_perr.delete(); cap_ferr.delete();
        rx_ready_a = 1'b1; cap_en = 1'b1;
        line_a = 1'b0;
        repeat (640) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        drive_frame(1'b0, 16'({1'b1, 8'h7E, 1'b0}), 10);
        repeat (10) @(negedge clk);
        check("break_words", 32'(cap_data.size()), 32'd2);
        if (cap_data.size() == 2) begin
            check("break_word", 32'(cap_data[0]), 32'h00);
            check("break_flags", 32'({cap_perr[0], cap_ferr[0]}), 32'd1);
            check("post_break_word", 32'(cap_data[1]), 32'h7E);
            check("post_break_flags", 32'({cap_perr[1], cap_ferr[1]}), 32'd0);
        end
        cap_en = 1'b0; rx_ready_a = 1'b0;
        repeat (10) @(negedge clk);

        // Reset halfway through the data bits of a looped-back 0x96
        cap_data.delete(); cap_perr.delete(); cap_ferr.delete();
        loop_a = 1'b1; rx_ready_a = 1'b1; cap_en = 1'b1;
        tx_data_a = 8'h96; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (79) @(negedge clk);
        check("pre_reset_line", 32'(uart_tx_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_uart_tx", 32'(uart_tx_a), 32'd1);
        check("reset_tx_ready", 32'(tx_ready_a), 32'd1);
        check("reset_rx_valid", 32'(rx_valid_a), 32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("reset_no_partial_word", 32'(cap_data.size()), 32'd0);
        check("reset_rx_valid_later", 32'(rx_valid_a), 32'd0);
        cap_en = 1'b0; loop_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
